// File: rtl/spi_reg_slave.sv
// SPI register slave: pending-buffered display settings for the render core.
// Writes land in pending buffers and go live only on the vblank load strobe.
module spi_reg_slave (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_ss_n,
    input  logic       i_load_new,
    output logic [5:0] o_sky,
    output logic [5:0] o_floor,
    output logic [5:0] o_leak,
    output logic [5:0] o_otherx,
    output logic [5:0] o_othery,
    output logic [5:0] o_vshift,
    output logic       o_vinf,
    output logic [5:0] o_mapdx,
    output logic [5:0] o_mapdy,
    output logic [1:0] o_mapdxw,
    output logic [1:0] o_mapdyw
);
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_HOLD} state_t;

    logic [2:0]  r_sclk_s;
    logic [1:0]  r_mosi_s;
    logic [1:0]  r_ss_s;
    state_t      r_state;
    logic [3:0]  r_cmd;
    logic [4:0]  r_cnt;
    logic [15:0] r_shift;

    logic [5:0]  r_sky, r_floor, r_leak, r_otherx, r_othery, r_vshift;
    logic        r_vinf;
    logic [5:0]  r_mapdx, r_mapdy;
    logic [1:0]  r_mapdxw, r_mapdyw;

    logic [5:0]  r_b_sky, r_b_floor, r_b_leak, r_b_vshift;
    logic [11:0] r_b_other;
    logic        r_b_vinf;
    logic [15:0] r_b_mapd;
    logic [6:0]  r_pend;

    logic        w_rise, w_bit, w_ss, w_last, w_commit;
    logic [3:0]  w_next_cmd;
    logic [4:0]  w_len;
    logic [15:0] w_data;
    logic [6:0]  w_set;

    assign w_rise     = r_sclk_s[1] & ~r_sclk_s[2];
    assign w_bit      = r_mosi_s[1];
    assign w_ss       = r_ss_s[1];
    assign w_next_cmd = {r_cmd[2:0], w_bit};
    assign w_data     = {r_shift[14:0], w_bit};
    assign w_last     = (r_cnt == w_len - 5'd1);
    assign w_commit   = (r_state == S_DATA) && w_rise && w_last && !w_ss;
    assign w_set      = w_commit ? (7'b1 << r_cmd[2:0]) : 7'b0;

    always_comb begin
        w_len = 5'd0;
        unique case (r_cmd[2:0])
            3'd0, 3'd1, 3'd2, 3'd4: w_len = 5'd6;
            3'd3:    w_len = 5'd12;
            3'd5:    w_len = 5'd1;
            3'd6:    w_len = 5'd16;
            default: w_len = 5'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_s <= 3'b000;
            r_mosi_s <= 2'b00;
            r_ss_s   <= 2'b11;
            r_state  <= S_IDLE;
            r_cmd    <= 4'd0;
            r_cnt    <= 5'd0;
            r_shift  <= 16'd0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], i_sclk};
            r_mosi_s <= {r_mosi_s[0], i_mosi};
            r_ss_s   <= {r_ss_s[0], i_ss_n};
            // Deselect wins from any state; an unfinished payload is dropped.
            if (w_ss) begin
                r_state <= S_IDLE;
            end else begin
                unique case (r_state)
                    S_IDLE: begin
                        r_state <= S_CMD;
                        r_cnt   <= 5'd0;
                        r_cmd   <= 4'd0;
                    end
                    S_CMD: if (w_rise) begin
                        r_cmd <= w_next_cmd;
                        if (r_cnt == 5'd3) begin
                            r_cnt   <= 5'd0;
                            r_shift <= 16'd0;
                            r_state <= (w_next_cmd < 4'd7) ? S_DATA : S_HOLD;
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    S_DATA: if (w_rise) begin
                        r_shift <= w_data;
                        r_cnt   <= r_cnt + 5'd1;
                        if (w_last) r_state <= S_HOLD;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sky      <= 6'b010101;
            r_floor    <= 6'b101010;
            r_leak     <= 6'd0;
            r_otherx   <= 6'd0;
            r_othery   <= 6'd0;
            r_vshift   <= 6'd0;
            r_vinf     <= 1'b0;
            r_mapdx    <= 6'd0;
            r_mapdy    <= 6'd0;
            r_mapdxw   <= 2'd0;
            r_mapdyw   <= 2'd0;
            r_b_sky    <= 6'b010101;
            r_b_floor  <= 6'b101010;
            r_b_leak   <= 6'd0;
            r_b_other  <= 12'd0;
            r_b_vshift <= 6'd0;
            r_b_vinf   <= 1'b0;
            r_b_mapd   <= 16'd0;
            r_pend     <= 7'd0;
        end else begin
            if (i_load_new) begin
                if (r_pend[0]) r_sky <= r_b_sky;
                if (r_pend[1]) r_floor <= r_b_floor;
                if (r_pend[2]) r_leak <= r_b_leak;
                if (r_pend[3]) {r_otherx, r_othery} <= r_b_other;
                if (r_pend[4]) r_vshift <= r_b_vshift;
                if (r_pend[5]) r_vinf <= r_b_vinf;
                if (r_pend[6]) {r_mapdx, r_mapdy, r_mapdxw, r_mapdyw} <= r_b_mapd;
            end
            // A commit racing the strobe stays pending for the next one.
            r_pend <= (r_pend & ~{7{i_load_new}}) | w_set;
            if (w_commit) begin
                unique case (r_cmd[2:0])
                    3'd0:    r_b_sky    <= w_data[5:0];
                    3'd1:    r_b_floor  <= w_data[5:0];
                    3'd2:    r_b_leak   <= w_data[5:0];
                    3'd3:    r_b_other  <= w_data[11:0];
                    3'd4:    r_b_vshift <= w_data[5:0];
                    3'd5:    r_b_vinf   <= w_data[0];
                    3'd6:    r_b_mapd   <= w_data;
                    default: ;
                endcase
            end
        end
    end

    assign o_sky    = r_sky;
    assign o_floor  = r_floor;
    assign o_leak   = r_leak;
    assign o_otherx = r_otherx;
    assign o_othery = r_othery;
    assign o_vshift = r_vshift;
    assign o_vinf   = r_vinf;
    assign o_mapdx  = r_mapdx;
    assign o_mapdy  = r_mapdy;
    assign o_mapdxw = r_mapdxw;
    assign o_mapdyw = r_mapdyw;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: model snapshots queued at each strobe,
// popped and compared against the live outputs after the load edge.
module tb_spi_reg_slave;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_sclk = 1'b0;
    logic       i_mosi = 1'b0;
    logic       i_ss_n = 1'b1;
    logic       i_load_new = 1'b0;
    logic [5:0] o_sky, o_floor, o_leak, o_otherx, o_othery, o_vshift;
    logic       o_vinf;
    logic [5:0] o_mapdx, o_mapdy;
    logic [1:0] o_mapdxw, o_mapdyw;

    spi_reg_slave dut (
        .clk(clk), .reset(reset), .i_sclk(i_sclk), .i_mosi(i_mosi),
        .i_ss_n(i_ss_n), .i_load_new(i_load_new),
        .o_sky(o_sky), .o_floor(o_floor), .o_leak(o_leak),
        .o_otherx(o_otherx), .o_othery(o_othery), .o_vshift(o_vshift),
        .o_vinf(o_vinf), .o_mapdx(o_mapdx), .o_mapdy(o_mapdy),
        .o_mapdxw(o_mapdxw), .o_mapdyw(o_mapdyw)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] sky, flr, leak, ox, oy, vs;
        logic       vinf;
        logic [5:0] mdx, mdy;
        logic [1:0] mdxw, mdyw;
    } outs_t;

    outs_t       m_live;
    outs_t       exp_q[$];
    logic [15:0] m_buf[7];
    logic        m_pend[7];
    int          n_chk = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_live = '0;
        m_live.sky = 6'b010101;
        m_live.flr = 6'b101010;
        for (int c = 0; c < 7; c++) begin
            m_buf[c] = 16'd0;
            m_pend[c] = 1'b0;
        end
        m_buf[0] = 16'h15;
        m_buf[1] = 16'h2A;
    endtask

    task automatic model_commit(input int c, input logic [15:0] d);
        m_buf[c] = d;
        m_pend[c] = 1'b1;
    endtask

    task automatic model_load();
        for (int c = 0; c < 7; c++) begin
            if (m_pend[c]) begin
                case (c)
                    0: m_live.sky = m_buf[c][5:0];
                    1: m_live.flr = m_buf[c][5:0];
                    2: m_live.leak = m_buf[c][5:0];
                    3: {m_live.ox, m_live.oy} = m_buf[c][11:0];
                    4: m_live.vs = m_buf[c][5:0];
                    5: m_live.vinf = m_buf[c][0];
                    default: {m_live.mdx, m_live.mdy, m_live.mdxw,
                              m_live.mdyw} = m_buf[c];
                endcase
                m_pend[c] = 1'b0;
            end
        end
    endtask

    task automatic check_outs(input string ph);
        outs_t e;
        if (exp_q.size() == 0) begin
            check({ph, "_q_empty"}, 16'd1, 16'd0);
            return;
        end
        e = exp_q.pop_front();
        check({ph, "_sky"},   o_sky,    e.sky);
        check({ph, "_floor"}, o_floor,  e.flr);
        check({ph, "_leak"},  o_leak,   e.leak);
        check({ph, "_ox"},    o_otherx, e.ox);
        check({ph, "_oy"},    o_othery, e.oy);
        check({ph, "_vs"},    o_vshift, e.vs);
        check({ph, "_vinf"},  o_vinf,   e.vinf);
        check({ph, "_mdx"},   o_mapdx,  e.mdx);
        check({ph, "_mdy"},   o_mapdy,  e.mdy);
        check({ph, "_mdxw"},  o_mapdxw, e.mdxw);
        check({ph, "_mdyw"},  o_mapdyw, e.mdyw);
    endtask

    task automatic expect_now(input string ph);
        exp_q.push_back(m_live);
        check_outs(ph);
    endtask

    task automatic do_load(input string ph);
        @(negedge clk);
        i_load_new = 1'b1;
        model_load();
        exp_q.push_back(m_live);
        @(posedge clk);
        #1 i_load_new = 1'b0;
        check_outs(ph);
    endtask

    // Free-running SPI at f_clk/6 with a random phase against clk.
    task automatic spi_xfer(input logic [31:0] w, input int n);
        #($urandom_range(1, 9));
        i_ss_n = 1'b0;
        #40;
        for (int i = n - 1; i >= 0; i--) begin
            i_mosi = w[i];
            #30 i_sclk = 1'b1;
            #30 i_sclk = 1'b0;
        end
        #30 i_ss_n = 1'b1;
        #60;
    endtask

    // Clock-aligned SPI so the last bit's commit lands on the strobe cycle.
    task automatic spi_collide(input logic [31:0] w, input int n,
                               input int c, input logic [15:0] d);
        @(posedge clk);
        #1 i_ss_n = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            #1 i_mosi = w[i];
            repeat (3) @(posedge clk);
            #1 i_sclk = 1'b1;
            if (i == 0) begin
                @(posedge clk);
                @(posedge clk);
                #1 i_load_new = 1'b1;
                model_load();
                exp_q.push_back(m_live);
                @(posedge clk);
                #1 i_load_new = 1'b0;
                check_outs("collide");
                model_commit(c, d);
            end else begin
                repeat (3) @(posedge clk);
            end
            #1 i_sclk = 1'b0;
        end
        repeat (4) @(posedge clk);
        #1 i_ss_n = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        model_reset();
        #25 reset = 1'b0;
        #20;
        expect_now("reset");

        spi_xfer({4'd0, 6'b110011}, 10);
        model_commit(0, 16'b110011);
        expect_now("sky_pre");
        do_load("sky");

        spi_xfer({4'd6, 16'b000101_001010_10_01}, 20);
        model_commit(6, 16'b000101_001010_10_01);
        do_load("mapd");

        spi_xfer({4'd1, 3'b111}, 7);
        do_load("abort");

        spi_xfer({4'hF, 20'hABCDE}, 24);
        do_load("resv");

        spi_xfer({4'd2, 6'd7}, 10);
        model_commit(2, 16'd7);
        spi_xfer({4'd2, 6'd9, 4'b1111}, 14);
        model_commit(2, 16'd9);
        do_load("leak");

        spi_xfer({4'd3, 6'd33, 6'd12}, 16);
        model_commit(3, {4'd0, 6'd33, 6'd12});
        spi_xfer({4'd4, 6'd45}, 10);
        model_commit(4, 16'd45);
        spi_xfer({4'd5, 1'b1}, 5);
        model_commit(5, 16'd1);
        do_load("multi");

        spi_collide({4'd0, 6'b001110}, 10, 0, 16'b001110);
        do_load("after_coll");
        do_load("noop");

        spi_xfer({4'd1, 6'b000111}, 10);
        model_commit(1, 16'b000111);
        i_ss_n = 1'b0;
        #40;
        for (int i = 0; i < 5; i++) begin
            i_mosi = i[0];
            #30 i_sclk = 1'b1;
            #30 i_sclk = 1'b0;
        end
        #7 reset = 1'b1;
        model_reset();
        i_ss_n = 1'b1;
        #23 reset = 1'b0;
        #20;
        expect_now("mid_rst");
        do_load("rst_load");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

Buffered SPI register slave feeding the rbzero render core with its general-purpose display registers (sky/floor colours, leak, other-wall, vertical shift, map divider). Sits between the chip's register SPI pins (i_reg_sclk/i_reg_mosi/i_reg_ss_n) and the core's register inputs. Writes are captured into a pending buffer and applied to the live outputs only on a load strobe from the frame timing, so a frame is never rendered with half-updated settings.

## Interface
- none: the register map is fixed.

- clk  in  1  system clock (pixel clock domain)
- reset  in  1  asynchronous, active-high reset
- i_sclk  in  1  SPI clock, asynchronous to clk, mode 0
- i_mosi  in  1  SPI data, MSB first, asynchronous
- i_ss_n  in  1  SPI select, active-low, asynchronous
- i_load_new  in  1  one-cycle strobe at start of vblank; applies pending writes
- o_sky  out  6  sky colour (BBGGRR)
- o_floor  out  6  floor colour
- o_leak  out  6  floor leak row count
- o_otherx  out  6  "other wall" X cell
- o_othery  out  6  "other wall" Y cell
- o_vshift  out  6  vertical texture shift
- o_vinf  out  1  infinite-height mode
- o_mapdx  out  6  map divider X
- o_mapdy  out  6  map divider Y
- o_mapdxw  out  2  map divider X wall type
- o_mapdyw  out  2  map divider Y wall type

## Operation
- Each of i_sclk, i_mosi, i_ss_n passes through 2 sync flops, plus a 3rd sclk flop for edge detect; sclk rise = stage2 high and stage3 low.
- MOSI bit taken from mosi stage2 on detected sclk rise.
- Transaction: 4-bit command, then payload. Lengths: 0 SKY 6; 1 FLOOR 6; 2 LEAK 6; 3 OTHER 12 (otherx then othery); 4 VSHIFT 6; 5 VINF 1; 6 MAPD 16 (mapdx, mapdy, mapdxw, mapdyw); 7-15 reserved.
- FSM: IDLE -> CMD on synced ss_n low; CMD shifts 4 bits -> DATA (valid cmd) or HOLD (reserved); DATA shifts payload, on last bit commits and -> HOLD; HOLD ignores all bits; any state -> IDLE when synced ss_n high.
- ss_n rising before the last payload bit: transaction aborted, nothing committed.
- Commit: payload copied into that register's pending buffer and its pending flag is set. A later commit to the same register overwrites the buffer.
- i_load_new: every register with pending flag set copies buffer to live output, and its flag clears. Registers without the flag hold their value.
- Commit and i_load_new in the same cycle: load uses the old buffer state. The new commit stays pending until the next i_load_new.
- Reset (async, any time, including mid-transaction): FSM IDLE, counters 0, sync flops 0 except ss_n chain 1, all pending flags clear. Outputs: o_sky 6'b010101, o_floor 6'b101010, o_leak 0, o_otherx 0, o_othery 0, o_vshift 0, o_vinf 0, o_mapdx 0, o_mapdy 0, o_mapdxw 0, o_mapdyw 0. Pending buffers reset to the same values.

## Timing
- Pin edge to detected sclk rise: 3 clk cycles. sclk high and low phases must each be >= 3 clk periods (f_sclk <= f_clk/6). ss_n setup to first sclk rise >= 3 clk periods.
- Pending flag and buffer update on the clk edge after the last payload bit's detected rise.
- Live outputs change on the clk edge where i_load_new is sampled high, i.e. visible the cycle after the strobe. They are registered and glitch-free.
- No backpressure. A strobe with nothing pending is a no-op.

## Test plan
- Reset: assert reset with a transaction in flight -> all outputs at reset values, no pending flags; a following i_load_new changes nothing.
- Write SKY: cmd 0000, data 110011, then i_load_new -> o_sky 6'b110011 one cycle after the strobe; o_sky unchanged before the strobe.
- MAPD 16-bit write 0110 + 000101_001010_10_01 -> after load: mapdx 5, mapdy 10, mapdxw 2, mapdyw 1.
- Abort: cmd 0001, 3 bits sent, ss_n high, then i_load_new -> o_floor stays 6'b101010. Reserved cmd 1111 + 20 bits -> no output changes.
- Collision: last payload bit's commit lands in the same cycle as i_load_new -> output unchanged after that strobe, updated after the next strobe.
- Double write: LEAK 7 then LEAK 9 before the strobe -> o_leak 9 after load. Extra bits after the payload are ignored. Run all cases at f_sclk = f_clk/6 with random phase.
